fetch_buffer_stage: RTL and testbench
=====================================

// Module: fetch_buffer_stage
// PURPOSE
//  Parametrised instruction-fetch front end: PC generator, IMEM request port and DEPTH-entry
//  {pc,inst} queue decoupling IMEM latency/stalls from decode. Sits between icache (Memory151)
//  and decode/regfile read. Adds valid/ready output, multi-entry buffering and redirect flush
//  with in-flight response squash. Redirects come from X (jump) or MW (branch/pc_sel).
// PARAMETERS
//  XLEN      32            data/address width
//  DEPTH     4             queue entries, power of two, >=2
//  RESET_PC  32'h0000_2000 first fetch address after reset
//  NOP_INST  32'h0000_0013 value driven on out_inst when out_valid=0 (`INSTR_NOP)
// PORTS
//  clk             in   1      clock, all state on posedge
//  reset           in   1      asynchronous, active-low reset
//  stall           in   1      icache stall; 1 = IMEM busy, hold request
//  redirect_valid  in   1      flush + new fetch target this cycle
//  redirect_pc     in   XLEN   new target; bits [1:0] forced to 0
//  icache_addr     out  XLEN   fetch address
//  icache_re       out  1      read enable (request issue)
//  icache_dout     in   32     instruction, valid in response cycle (see BEHAVIOUR)
//  out_valid       out  1      head entry valid
//  out_ready       in   1      decode accepts head
//  out_pc          out  XLEN   PC of head entry
//  out_inst        out  32     head instruction; NOP_INST when !out_valid
//  occupancy       out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  Reset (async assert, sync deassert used by upstream): fetch_pc=RESET_PC, inflight=0, drop=0,
//   count=0, out_valid=0, out_pc=0, out_inst=NOP_INST, icache_re=0, icache_addr=RESET_PC.
//  Issue: icache_re=1 iff !redirect_valid && !inflight_blocked && (count+inflight)<DEPTH; on issue
//   icache_addr=fetch_pc, req_pc<=fetch_pc, fetch_pc<=fetch_pc+4 (mod 2^XLEN), inflight<=1.
//   Issue gated combinationally only by !stall for new requests; while stall=1 an issued request
//   holds icache_addr/icache_re stable, fetch_pc unchanged.
//  Response: resp = inflight && !stall; icache_dout sampled that cycle. Push {req_pc,icache_dout}
//   unless drop=1 or redirect_valid=1. A new issue may occur in the same cycle as resp (1 inst/cycle
//   steady state when DEPTH>=2 and out_ready=1). inflight clears on resp without new issue.
//  Pop: out_valid && out_ready. Push+pop same cycle: count unchanged, wrap pointers mod DEPTH.
//   Full (count=DEPTH): no issue; held response cannot occur since credit check counts inflight.
//   Empty: out_valid=0, no bypass (push visible next cycle; latency issue->out_valid = 2 cycles
//   with stall=0).
//  Redirect (priority over push/pop/issue): queue emptied, count<=0, fetch_pc<=redirect_pc&~3,
//   no issue that cycle; if inflight and !resp -> drop<=1 (next response discarded, drop cleared
//   then); if resp same cycle, that data discarded. First post-redirect fetch issues next cycle.
//  Redirect while stall=1: icache_re/addr keep old request until resp; that resp dropped.
//  Back-to-back redirects: last wins; drop stays set until one response consumed.
//  out_* registered from queue head; combinational only through read mux.
// STRUCTURE
//  const.vh: INSTR_NOP, RESET_PC defaults shared with PC/decode.
//  Sub-module fetch_fifo (DEPTH, WIDTH=XLEN+32): sync FIFO with flush, push/pop, count,
//   async active-low reset; parent holds PC/inflight/drop logic (~250 lines total).
// TESTING
//  1 Reset, stall=0, out_ready=1, IMEM model -> icache_addr 0x2000,0x2004,...; out_pc seq 0x2000..
//    one/cycle after 2-cycle latency, out_inst=mem[pc].
//  2 out_ready=0 for 10 cycles, DEPTH=4 -> occupancy saturates 4, icache_re=0, no lost/duplicate
//    inst on resume.
//  3 stall=1 for 3 cycles mid-request -> icache_addr stable, no push; release -> single push.
//  4 redirect_pc=0x3002 with inflight and stall=1 -> queue empty next cycle, stale resp dropped,
//    next out_pc=0x3000.
//  5 redirect same cycle as resp and pop -> occupancy 0, resp discarded, no out_valid glitch.
//  6 reset asserted mid-stream (async, between edges) -> all outputs to reset values immediately.

Source files
------------

// File: rtl/fetch_buffer_stage_pkg.sv
// Shared fetch-front-end constants: NOP encoding, boot PC and queue sizing helper.
package fetch_buffer_stage_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;
  localparam logic [31:0] PC_RESET  = 32'h0000_2000;
  localparam int unsigned PC_STEP   = 4;

  // Counter width able to hold 0..depth inclusive.
  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fetch_buffer_stage_fifo.sv
// Synchronous {pc,inst} queue with flush; head is read combinationally from storage.
module fetch_fifo
  import fetch_buffer_stage_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [WIDTH-1:0]        data_i,
  output logic [WIDTH-1:0]        data_o,
  output logic                    valid_o,
  output logic [cnt_w(DEPTH)-1:0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Payload storage carries no reset; validity comes from count_q alone.
  always_ff @(posedge clk_i) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer_stage.sv
// Instruction fetch front end: PC generation, single-outstanding IMEM request tracking,
// redirect flush with stale-response squash, and a DEPTH-entry queue toward decode.
module fetch_buffer_stage
  import fetch_buffer_stage_pkg::*;
#(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(PC_RESET),
  parameter logic [31:0]     NOP_INST = INSTR_NOP
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    stall,
  input  logic                    redirect_valid,
  input  logic [XLEN-1:0]         redirect_pc,
  output logic [XLEN-1:0]         icache_addr,
  output logic                    icache_re,
  input  logic [31:0]             icache_dout,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_pc,
  output logic [31:0]             out_inst,
  output logic [$clog2(DEPTH):0]  occupancy
);

  localparam int unsigned CW = cnt_w(DEPTH);
  localparam int unsigned EW = XLEN + 32;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            inflight_q, inflight_d;
  logic            drop_q, drop_d;
  logic            started_q;

  logic            resp, held, credit_ok, issue, push, pop;
  logic [CW:0]     pending;
  logic [CW-1:0]   count;
  logic            head_vld;
  logic [EW-1:0]   head_data;

  // Credit counts the outstanding request so a response always has a free slot.
  assign resp      = inflight_q && !stall;
  assign held      = inflight_q && stall;
  assign pending   = {1'b0, count} + (CW+1)'(inflight_q);
  assign credit_ok = pending < (CW+1)'(DEPTH);
  assign issue     = started_q && !stall && !redirect_valid && credit_ok;

  assign icache_re   = issue || held;
  assign icache_addr = held ? req_pc_q : fetch_pc_q;

  assign push = resp && !drop_q && !redirect_valid;
  assign pop  = head_vld && out_ready && !redirect_valid;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    req_pc_d   = req_pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (issue) begin
      req_pc_d   = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + XLEN'(PC_STEP);
      inflight_d = 1'b1;
    end else if (resp) begin
      inflight_d = 1'b0;
    end
    // A redirect with a request still out marks its eventual response as stale.
    if (resp) begin
      drop_d = 1'b0;
    end else if (redirect_valid && inflight_q) begin
      drop_d = 1'b1;
    end
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      drop_q     <= 1'b0;
      started_q  <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_pc_q   <= req_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
      started_q  <= 1'b1;
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (reset),
    .flush_i (redirect_valid),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({req_pc_q, icache_dout}),
    .data_o  (head_data),
    .valid_o (head_vld),
    .count_o (count)
  );

  assign out_valid = head_vld;
  assign out_pc    = head_vld ? head_data[EW-1:32] : '0;
  assign out_inst  = head_vld ? head_data[31:0] : NOP_INST;
  assign occupancy = count;

endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Directed bench for fetch_buffer_stage with a one-cycle IMEM model.
module tb_fetch_buffer_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] icache_addr;
  logic        icache_re;
  logic [31:0] icache_dout;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic [2:0]  occupancy;
  logic [31:0] mem_addr = 32'h0;

  int checks = 0;
  int errors = 0;

  fetch_buffer_stage #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h0000_2000),
    .NOP_INST (32'h0000_0013)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .icache_addr    (icache_addr),
    .icache_re      (icache_re),
    .icache_dout    (icache_dout),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .occupancy      (occupancy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0013;
  endfunction

  // IMEM: captures an accepted request, answers in the following non-stalled cycle.
  always @(posedge clk) begin
    if (icache_re && !stall) mem_addr <= icache_addr;
  end
  assign icache_dout = inst_of(mem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'h0);
    chk({tag, "_pc"},    out_pc,         32'h0);
    chk({tag, "_inst"},  out_inst,       32'h0000_0013);
    chk({tag, "_re"},    32'(icache_re), 32'h0);
    chk({tag, "_addr"},  icache_addr,    32'h0000_2000);
    chk({tag, "_occ"},   32'(occupancy), 32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] p;
    reset          = 1'b0;
    stall          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk_reset_outputs("rst");

    // Streaming fetch after reset release.
    tick();
    reset = 1'b1;
    #1;
    chk("boot_re_idle", 32'(icache_re), 32'h0);
    tick();
    chk("s1_re", 32'(icache_re), 32'h1);
    chk("s1_addr", icache_addr, 32'h0000_2000);
    tick();
    chk("s2_addr", icache_addr, 32'h0000_2004);
    chk("s2_valid", 32'(out_valid), 32'h0);
    tick();
    chk("s3_valid", 32'(out_valid), 32'h1);
    chk("s3_pc", out_pc, 32'h0000_2000);
    chk("s3_inst", out_inst, inst_of(32'h0000_2000));
    chk("s3_addr", icache_addr, 32'h0000_2008);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("stream_pc", out_pc, 32'h0000_2000 + 32'(4 * i));
      chk("stream_occ", 32'(occupancy), 32'h1);
    end

    // Backpressure: queue fills to DEPTH and issue stops.
    p = 32'h0000_2010;
    out_ready = 1'b0;
    repeat (10) tick();
    chk("bp_occ", 32'(occupancy), 32'h4);
    chk("bp_re", 32'(icache_re), 32'h0);
    chk("bp_head", out_pc, p);
    out_ready = 1'b1;
    #1;
    for (int i = 0; i <= 5; i++) begin
      chk("resume_valid", 32'(out_valid), 32'h1);
      chk("resume_pc", out_pc, p + 32'(4 * i));
      chk("resume_inst", out_inst, inst_of(p + 32'(4 * i)));
      tick();
    end

    // Asynchronous reset between edges.
    chk("pre_rst_valid", 32'(out_valid), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_outputs("async_rst");
    tick();
    tick();
    reset = 1'b1;

    // Stall across a pending response.
    tick();
    chk("st_issue_addr", icache_addr, 32'h0000_2000);
    tick();
    stall = 1'b1;
    #1;
    chk("st_hold_re", 32'(icache_re), 32'h1);
    chk("st_hold_addr1", icache_addr, 32'h0000_2000);
    tick();
    chk("st_hold_addr2", icache_addr, 32'h0000_2000);
    chk("st_no_push2", 32'(occupancy), 32'h0);
    tick();
    chk("st_hold_addr3", icache_addr, 32'h0000_2000);
    chk("st_no_push3", 32'(out_valid), 32'h0);
    tick();
    stall = 1'b0;
    #1;
    chk("st_release_addr", icache_addr, 32'h0000_2004);
    tick();
    chk("st_single_occ", 32'(occupancy), 32'h1);
    chk("st_single_pc", out_pc, 32'h0000_2000);
    chk("st_single_inst", out_inst, inst_of(32'h0000_2000));
    tick();
    chk("st_next_pc", out_pc, 32'h0000_2004);

    // Redirect while stalled with a request outstanding.
    tick();
    stall          = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_3002;
    #1;
    chk("rd_hold_re", 32'(icache_re), 32'h1);
    chk("rd_hold_addr", icache_addr, 32'h0000_200C);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rd_flush_occ", 32'(occupancy), 32'h0);
    chk("rd_flush_valid", 32'(out_valid), 32'h0);
    chk("rd_flush_inst", out_inst, 32'h0000_0013);
    chk("rd_still_held", icache_addr, 32'h0000_200C);
    tick();
    stall = 1'b0;
    #1;
    chk("rd_new_addr", icache_addr, 32'h0000_3000);
    chk("rd_new_re", 32'(icache_re), 32'h1);
    tick();
    chk("rd_stale_dropped", 32'(occupancy), 32'h0);
    tick();
    chk("rd_first_valid", 32'(out_valid), 32'h1);
    chk("rd_first_pc", out_pc, 32'h0000_3000);
    chk("rd_first_inst", out_inst, inst_of(32'h0000_3000));

    // Redirect coinciding with a response and a pop.
    tick();
    chk("rp_head", out_pc, 32'h0000_3004);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_5000;
    #1;
    chk("rp_no_issue", 32'(icache_re), 32'h0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("rp_occ", 32'(occupancy), 32'h0);
    chk("rp_valid", 32'(out_valid), 32'h0);
    chk("rp_addr", icache_addr, 32'h0000_5000);
    tick();
    chk("rp_no_glitch", 32'(out_valid), 32'h0);
    chk("rp_discarded_occ", 32'(occupancy), 32'h0);
    tick();
    chk("rp_new_valid", 32'(out_valid), 32'h1);
    chk("rp_new_pc", out_pc, 32'h0000_5000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
